// File: rtl/rc4_ctrl_if.sv
// Byte-stream bundle of rc4_ctrl: key loading, input data and XORed output.
// The slave side belongs to the controller; the master side belongs to its environment.
interface rc4_ctrl_if;
  logic       key_valid;
  logic [7:0] key_data;
  logic       key_ready;
  logic       data_valid;
  logic [7:0] data_in;
  logic       data_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;

  modport master (
    output key_valid, key_data, data_valid, data_in, out_ready,
    input  key_ready, data_ready, out_valid, out_data
  );

  modport slave (
    input  key_valid, key_data, data_valid, data_in, out_ready,
    output key_ready, data_ready, out_valid, out_data
  );
endinterface

// File: rtl/rc4_ctrl.sv
// Sequencer for the rc4 keystream core: key load/replay, scheduling, throttled keystream FIFO, XOR.
// Define RC4_CTRL_DROP_EN to discard the first DROP_N keystream bytes (RC4-drop[N]).
module rc4_ctrl #(
  parameter int KEY_SIZE   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_N     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  rc4_ctrl_if.slave  bus,
  output logic       busy,
  output logic       keyed,
  output logic       core_rst,
  output logic       core_en,
  output logic [7:0] core_key,
  input  logic       core_ready,
  input  logic [7:0] core_k
);

  localparam int IDX_W = $clog2(KEY_SIZE + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam logic [IDX_W-1:0] KEY_LAST = IDX_W'(KEY_SIZE - 1);
  localparam logic [IDX_W-1:0] KEY_END  = IDX_W'(KEY_SIZE);
  localparam logic [CW-1:0]    DEPTH_C  = CW'(FIFO_DEPTH);

  if (KEY_SIZE < 1 || KEY_SIZE > 256 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DROP_N < 0 || DROP_N > 4095) begin : g_bad_param
    $error("rc4_ctrl: parameter out of range");
  end

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CRST,
    FEED,
    SCHED,
`ifdef RC4_CTRL_DROP_EN
    DROP,
`endif
    RUN
  } state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;
  logic [7:0]       kbuf [2**IDX_W];
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             pend;
  logic             flush, push, pop;

`ifdef RC4_CTRL_DROP_EN
  localparam logic [11:0] DROP_LAST = 12'(DROP_N - 1);
  logic [11:0] drop_cnt;
`endif

  // A restart in RUN wins over the output path: nothing is popped or pushed that cycle.
  assign flush          = (state == RUN) && start;
  assign push           = pend && !flush;
  assign keyed          = (state == RUN);
  assign busy           = (state != IDLE) && (state != RUN);
  assign bus.out_valid  = keyed && bus.data_valid && (count != '0) && !flush;
  assign bus.out_data   = bus.data_in ^ fifo_mem[rd_ptr];
  assign pop            = bus.out_valid && bus.out_ready;
  assign bus.data_ready = pop;

  always_comb begin
    state_nx      = state;
    idx_nx        = idx;
    bus.key_ready = 1'b0;
    core_rst      = 1'b0;
    core_en       = 1'b0;
    core_key      = 8'h00;
    unique case (state)
      IDLE: begin
        core_rst = 1'b1;
        if (start) begin
          state_nx = LOAD;
          idx_nx   = '0;
        end
      end
      LOAD: begin
        bus.key_ready = 1'b1;
        if (bus.key_valid) begin
          if (idx == KEY_LAST) begin
            idx_nx   = '0;
            state_nx = CRST;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      CRST: begin
        core_rst = 1'b1;
        state_nx = FEED;
      end
      // Key bytes go out back-to-back, followed by one zero byte.
      FEED: begin
        core_en = 1'b1;
        if (idx == KEY_END) begin
          idx_nx   = '0;
          state_nx = SCHED;
        end else begin
          core_key = kbuf[idx];
          idx_nx   = idx + 1'b1;
        end
      end
      SCHED: begin
        core_en = 1'b1;
        if (core_ready) begin
`ifdef RC4_CTRL_DROP_EN
          state_nx = (DROP_N > 0) ? DROP : RUN;
`else
          state_nx = RUN;
`endif
        end
      end
`ifdef RC4_CTRL_DROP_EN
      DROP: begin
        core_en = 1'b1;
        if (drop_cnt == DROP_LAST) state_nx = RUN;
      end
`endif
      RUN: begin
        if (start) begin
          state_nx = LOAD;
          idx_nx   = '0;
        end else begin
          // Bytes already in flight count against free space, so the FIFO cannot overflow.
          core_en = (count + CW'(pend)) < DEPTH_C;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      idx    <= '0;
      pend   <= 1'b0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      pend  <= (state == RUN) && core_en;
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
    end
  end

`ifdef RC4_CTRL_DROP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt <= '0;
    else      drop_cnt <= (state == DROP) ? drop_cnt + 12'd1 : 12'd0;
  end
`endif

  always_ff @(posedge clk) begin
    if (state == LOAD && bus.key_valid) kbuf[idx] <= bus.key_data;
    if (push) fifo_mem[wr_ptr] <= core_k;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && count == DEPTH_C));

endmodule

// File: tb/tb_rc4_ctrl.sv
// Bench for rc4_ctrl: behavioural rc4 core stand-in, RC4 reference model and stream scoreboard.
module tb_rc4_ctrl;
  localparam int KS    = 3;
  localparam int DEPTH = 4;
  localparam int N_KSA = 4;
`ifdef RC4_CTRL_DROP_EN
  localparam int DROP = 3;
`else
  localparam int DROP = 0;
`endif

  typedef logic [7:0] key_t [0:KS-1];
  typedef logic [7:0] ks_t  [0:63];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       busy, keyed, core_rst, core_en, core_ready;
  logic [7:0] core_key;
  logic [7:0] core_k;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] dq[$];
  logic [7:0] eq[$];

  rc4_ctrl_if bus();

  rc4_ctrl #(.KEY_SIZE(KS), .FIFO_DEPTH(DEPTH), .DROP_N(DROP)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .busy(busy), .keyed(keyed), .core_rst(core_rst), .core_en(core_en),
    .core_key(core_key), .core_ready(core_ready), .core_k(core_k)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void rc4(input key_t k, output ks_t ks);
    int s[256];
    int i, j, t;
    for (int n = 0; n < 256; n++) s[n] = n;
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = (j + s[n] + int'(k[n % KS])) % 256;
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int n = 0; n < 64; n++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      ks[n] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endfunction

  // Stand-in for the keystream core: takes KS key bytes plus a zero byte,
  // schedules for N_KSA enabled cycles (core_ready on the last), then emits one byte per enable.
  int   m_phase = 0, m_cnt = 0, m_g = 0;
  key_t m_key;
  ks_t  m_ks;
  logic m_zero = 1'b0;
  assign core_ready = (m_phase == 1) && (m_cnt == N_KSA - 1);

  always @(posedge clk) begin
    if (core_rst) begin
      m_phase <= 0; m_cnt <= 0; m_g <= 0;
    end else if (core_en) begin
      case (m_phase)
        0: if (m_cnt < KS) begin
             m_key[m_cnt] <= core_key;
             m_cnt <= m_cnt + 1;
           end else begin
             m_zero  <= (core_key == 8'h00);
             m_phase <= 1;
             m_cnt   <= 0;
           end
        1: if (m_cnt == N_KSA - 1) begin
             rc4(m_key, m_ks);
             m_phase <= 2;
             m_g     <= 0;
           end else m_cnt <= m_cnt + 1;
        default: begin
          core_k <= m_ks[m_g];
          m_g    <= (m_g < 63) ? m_g + 1 : m_g;
        end
      endcase
    end
  end

  task automatic load_key(input key_t k);
    int w;
    @(posedge clk); #1;
    start = 1'b1; bus.key_valid = 1'b1; bus.key_data = k[0];
    bus.data_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    check("key_rdy_start", bus.key_ready, 0);
    check("dr_start", bus.data_ready, 0);
    @(posedge clk); #1;
    start = 1'b0; bus.data_valid = 1'b0;
    for (int b = 0; b < KS; b++) begin
      if (b > 0) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        bus.key_valid = 1'b1; bus.key_data = k[b];
      end
      w = 0;
      @(negedge clk);
      if (b == 0) begin
        check("keyed_clr", keyed, 0);
        check("busy_load", busy, 1);
      end
      while (!bus.key_ready && w < 20) begin @(negedge clk); w++; end
      check("key_rdy", bus.key_ready, 1);
      @(posedge clk); #1;
      bus.key_valid = 1'b0;
    end
  endtask

  task automatic stream(input int mode);
    int  got = 0, en_sum = 0, pop_sum = 0, cyc = 0;
    bit  tog = 1'b1;
    bit  hs;
    int  n = dq.size();
    forever begin
      check("core_en", core_en, (keyed && (en_sum - pop_sum) < DEPTH) ? 1 : 0);
      hs = bus.out_valid && bus.out_ready;
      check("data_ready", bus.data_ready, hs);
      if (hs) begin
        check("out_data", bus.out_data, eq[got]);
        got++;
      end
      en_sum += int'(core_en);
      pop_sum += int'(hs);
      if (got == n || cyc > 2000) break;
      @(posedge clk); #1;
      bus.data_in = dq[got];
      bus.data_valid = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      case (mode)
        0: bus.out_ready = 1'b1;
        1: begin bus.out_ready = tog; tog = !tog; end
        default: bus.out_ready = ($urandom_range(0, 1) == 1);
      endcase
      @(negedge clk);
      cyc++;
    end
    if (got != n) check("stream_count", got, n);
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
  endtask

  task automatic session(input key_t k, input int n, input int mode, input bit directed);
    ks_t ks;
    int  w = 0;
    logic [7:0] d;
    load_key(k);
    while (!keyed && w < 1000) begin @(negedge clk); w++; end
    check("keyed", keyed, 1);
    check("busy_run", busy, 0);
    for (int b = 0; b < KS; b++) check("core_key", m_key[b], k[b]);
    check("feed_zero", m_zero, 1);
    if (!directed) begin
      rc4(k, ks);
      dq.delete(); eq.delete();
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom);
        dq.push_back(d);
        eq.push_back(d ^ ks[DROP + i]);
      end
    end
    stream(mode);
  endtask

  initial begin
    key_t kk;
    ks_t  ks;
    int   w;
    bus.key_valid = 1'b0; bus.key_data = 8'h00; bus.data_valid = 1'b0;
    bus.data_in = 8'h00; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_key_ready", bus.key_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_data_ready", bus.data_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_keyed", keyed, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_core_en", core_en, 0);
    check("rst_core_key", core_key, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    kk = '{8'h4B, 8'h65, 8'h79};
    rc4(kk, ks);
`ifdef RC4_CTRL_DROP_EN
    dq = '{8'h00, 8'h00, 8'h00, 8'h00};
    eq = '{8'h81, 8'hB7, 8'h34, 8'hCA};
`else
    dq = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    eq = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
`endif
    session(kk, 0, 0, 1'b1);

    // Zero data with out_ready toggling: output is the raw keystream.
    dq.delete(); eq.delete();
    for (int i = 0; i < 10; i++) dq.push_back(8'h00);
`ifdef RC4_CTRL_DROP_EN
    for (int i = 0; i < 10; i++) eq.push_back(ks[DROP + i]);
`else
    eq = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
`endif
    session(kk, 0, 1, 1'b1);

    // Reset in the middle of FEED, then a clean restart.
    load_key(kk);
    w = 0;
    @(negedge clk);
    while (!(core_en && !core_rst) && w < 50) begin @(negedge clk); w++; end
    check("feed_seen", core_en, 1);
    bus.key_valid = 1'b1;
    rst = 1'b0;
    #1;
    check("mid_key_ready", bus.key_ready, 0);
    check("mid_core_rst", core_rst, 1);
    check("mid_core_en", core_en, 0);
    check("mid_busy", busy, 0);
    check("mid_keyed", keyed, 0);
    check("mid_core_key", core_key, 0);
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    dq = '{8'h00};
`ifdef RC4_CTRL_DROP_EN
    eq = '{8'h81};
`else
    eq = '{8'hEB};
`endif
    session(kk, 0, 0, 1'b1);

    // Random keys, data and back-pressure; short sessions exercise rekey while the FIFO holds bytes.
    for (int r = 0; r < 5; r++) begin
      for (int b = 0; b < KS; b++) kk[b] = 8'($urandom);
      session(kk, (r == 1) ? 2 : 12, $urandom_range(0, 2), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
